spi_mcp_master: RTL and testbench

- SPI source (mode 0) that generates MCP23S17-style single-register transactions: opcode byte, register address byte, one data byte.
- Sits directly upstream of the SPI sink responder. It drives sclk/csn/mosi into the sink and samples miso back.
- Converts a one-cycle start/done request interface in the fabric clock domain into SPI bit timing.

---
 rtl/spi_mcp_master_pkg.sv | 25 ++
 rtl/spi_mcp_master_sclk_div.sv | 36 +++
 rtl/spi_mcp_master.sv | 195 +++++++++++++++++++
 tb/tb_spi_mcp_master.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_mcp_master_pkg.sv
// Shared types and constants for the MCP23S17-style SPI source.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        FLUSH
    } spi_mst_state_t;

    localparam logic [3:0]  MCP_OPCODE_HI = 4'b0100;
    localparam int unsigned FRAME_BITS    = 24;

    // Opcode, register address, then data byte; reads carry a zero data byte.
    function automatic logic [23:0] mcp_frame(
        input logic [2:0] hw_addr,
        input logic       rw,
        input logic [7:0] reg_addr,
        input logic [7:0] wdata
    );
        return {MCP_OPCODE_HI, hw_addr, rw, reg_addr, (rw ? 8'h00 : wdata)};
    endfunction

endpackage

// File: rtl/spi_mcp_master_sclk_div.sv
// Half-period timer: counts HALF_DIV cycles per sclk phase and flags the
// last cycle of each phase as a rise (low phase ending) or fall strobe.
module spi_sclk_div #(
    parameter int unsigned HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_phase_end,
    output logic o_rise,
    output logic o_fall
);

    logic [7:0] r_cnt;
    logic       r_phase;

    assign o_phase_end = i_en && (r_cnt == 8'(HALF_DIV - 1));
    assign o_rise      = o_phase_end && !r_phase;
    assign o_fall      = o_phase_end && r_phase;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_en) begin
            if (o_phase_end) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_mcp_master.sv
// Mode-0 SPI source issuing single-register MCP23S17-style transactions.
// Each frame is followed by csn-high sclk pulses that return the sink to idle.
module spi_mcp_master
    import spi_pkg::*;
#(
    parameter int unsigned HALF_DIV     = 4,
    parameter logic [2:0]  HW_ADDR      = 3'b000,
    parameter int unsigned FLUSH_PULSES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rdata,
    output logic       sclk_o,
    output logic       csn_o,
    output logic       mosi_o,
    input  logic       miso_i
);

    spi_mst_state_t r_state, w_next;

    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic [7:0]  r_rdata, w_rdata;
    logic        r_sclk, w_sclk;
    logic        r_csn, w_csn;
    logic [23:0] r_frame, w_frame;
    logic [4:0]  r_bit, w_bit;
    logic [1:0]  r_pulse, w_pulse;
    logic [7:0]  r_rx, w_rx;
    logic        r_rw, w_rw;
    logic        r_txn, w_txn;
    logic        r_boot, w_boot;
    logic        r_miso_meta, r_miso_s;

    logic [23:0] w_new_frame;
    logic        w_div_en, w_div_clr;
    logic        w_phase_end, w_rise, w_fall;

    assign w_new_frame = mcp_frame(HW_ADDR, rw, reg_addr, wdata);
    assign w_div_en    = (r_state != IDLE);
    assign w_div_clr   = (w_next != r_state);

    spi_sclk_div #(
        .HALF_DIV(HALF_DIV)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_en       (w_div_en),
        .i_clr      (w_div_clr),
        .o_phase_end(w_phase_end),
        .o_rise     (w_rise),
        .o_fall     (w_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_miso_meta <= 1'b0;
            r_miso_s    <= 1'b0;
        end else begin
            r_miso_meta <= miso_i;
            r_miso_s    <= r_miso_meta;
        end
    end

    // mosi is the frame MSB; zero-fill shifting leaves it low once the frame is out.
    always_comb begin
        w_next  = r_state;
        w_busy  = r_busy;
        w_done  = 1'b0;
        w_rdata = r_rdata;
        w_sclk  = r_sclk;
        w_csn   = r_csn;
        w_frame = r_frame;
        w_bit   = r_bit;
        w_pulse = r_pulse;
        w_rx    = r_rx;
        w_rw    = r_rw;
        w_txn   = r_txn;
        w_boot  = r_boot;
        case (r_state)
            IDLE: begin
                if (r_boot) begin
                    w_next  = FLUSH;
                    w_boot  = 1'b0;
                    w_busy  = 1'b1;
                    w_pulse = '0;
                end else if (start) begin
                    w_next  = SETUP;
                    w_busy  = 1'b1;
                    w_csn   = 1'b0;
                    w_sclk  = 1'b0;
                    w_frame = w_new_frame;
                    w_rw    = rw;
                    w_txn   = 1'b1;
                    w_bit   = '0;
                end
            end
            SETUP: begin
                if (w_phase_end) begin
                    w_next = SHIFT;
                end
            end
            SHIFT: begin
                if (w_rise) begin
                    w_sclk = 1'b1;
                    if (r_bit[4]) begin
                        w_rx = {r_rx[6:0], r_miso_s};
                    end
                end else if (w_fall) begin
                    w_sclk  = 1'b0;
                    w_frame = {r_frame[22:0], 1'b0};
                    if (r_bit == 5'(FRAME_BITS - 1)) begin
                        w_next = HOLD;
                    end else begin
                        w_bit = r_bit + 5'd1;
                    end
                end
            end
            HOLD: begin
                if (w_phase_end) begin
                    w_next  = FLUSH;
                    w_csn   = 1'b1;
                    w_pulse = '0;
                end
            end
            FLUSH: begin
                if (w_rise) begin
                    w_sclk = 1'b1;
                end else if (w_fall) begin
                    w_sclk = 1'b0;
                    if (r_pulse == 2'(FLUSH_PULSES - 1)) begin
                        w_next = IDLE;
                        w_busy = 1'b0;
                        w_done = r_txn;
                        w_txn  = 1'b0;
                        if (r_txn && r_rw) begin
                            w_rdata = r_rx;
                        end
                    end else begin
                        w_pulse = r_pulse + 2'd1;
                    end
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 8'h00;
            r_sclk  <= 1'b0;
            r_csn   <= 1'b1;
            r_frame <= '0;
            r_bit   <= '0;
            r_pulse <= '0;
            r_rx    <= '0;
            r_rw    <= 1'b0;
            r_txn   <= 1'b0;
            r_boot  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_rdata <= w_rdata;
            r_sclk  <= w_sclk;
            r_csn   <= w_csn;
            r_frame <= w_frame;
            r_bit   <= w_bit;
            r_pulse <= w_pulse;
            r_rx    <= w_rx;
            r_rw    <= w_rw;
            r_txn   <= w_txn;
            r_boot  <= w_boot;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign rdata  = r_rdata;
    assign sclk_o = r_sclk;
    assign csn_o  = r_csn;
    assign mosi_o = r_frame[23];

endmodule

// File: tb/tb_spi_mcp_master.sv
// Bench for spi_mcp_master: two instances (default and HALF_DIV=3/HW_ADDR=5),
// each driving a behavioural mode-0 sink that captures mosi and returns td0.
module tb_spi_mcp_master;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] start = '0;
    logic [1:0] rw = '0;
    logic [7:0] addr [2];
    logic [7:0] wdata [2];
    logic [7:0] td0 [2];
    logic       miso0 = 1'b0;
    logic       miso1 = 1'b0;
    wire  [1:0] busy, done, sclk, csn, mosi;
    wire  [7:0] rdata0, rdata1;

    int cyc = 0;
    int nchk = 0;
    int nerr = 0;
    int busy_cnt [2] = '{0, 0};
    int csn_cnt  [2] = '{0, 0};
    int done_cnt [2] = '{0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_mcp_master u_dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .rw(rw[0]), .reg_addr(addr[0]),
        .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata0),
        .sclk_o(sclk[0]), .csn_o(csn[0]), .mosi_o(mosi[0]), .miso_i(miso0)
    );

    spi_mcp_master #(.HALF_DIV(3), .HW_ADDR(3'b101), .FLUSH_PULSES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .rw(rw[1]), .reg_addr(addr[1]),
        .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata1),
        .sclk_o(sclk[1]), .csn_o(csn[1]), .mosi_o(mosi[1]), .miso_i(miso1)
    );

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (busy[i] === 1'b1) busy_cnt[i] <= busy_cnt[i] + 1;
            if (csn[i] === 1'b0)  csn_cnt[i]  <= csn_cnt[i] + 1;
            if (done[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    // Sink 0: shift mosi on rise, present td0 MSB-first after 16 bits, reset on csn-high pulse.
    logic [23:0] sh0 = '0, fr0 = '0;
    logic [7:0]  rcv0 = '0;
    int          bc0 = 0, nf0 = 0;
    always @(posedge sclk[0]) begin
        if (csn[0] == 1'b0) begin sh0 <= {sh0[22:0], mosi[0]}; bc0 <= bc0 + 1; end
        else bc0 <= 0;
    end
    always @(negedge sclk[0]) if (csn[0] == 1'b0 && bc0 >= 16 && bc0 < 24) miso0 <= td0[0][23 - bc0];
    always @(posedge csn[0]) if (bc0 == 24) begin
        nf0 <= nf0 + 1; fr0 <= sh0;
        if (!sh0[16]) rcv0 <= sh0[7:0];
    end

    logic [23:0] sh1 = '0, fr1 = '0;
    logic [7:0]  rcv1 = '0;
    int          bc1 = 0, nf1 = 0;
    always @(posedge sclk[1]) begin
        if (csn[1] == 1'b0) begin sh1 <= {sh1[22:0], mosi[1]}; bc1 <= bc1 + 1; end
        else bc1 <= 0;
    end
    always @(negedge sclk[1]) if (csn[1] == 1'b0 && bc1 >= 16 && bc1 < 24) miso1 <= td0[1][23 - bc1];
    always @(posedge csn[1]) if (bc1 == 24) begin
        nf1 <= nf1 + 1; fr1 <= sh1;
        if (!sh1[16]) rcv1 <= sh1[7:0];
    end

    function automatic logic [23:0] frame_of(input int d);
        return (d == 0) ? fr0 : fr1;
    endfunction
    function automatic logic [7:0] rcv_of(input int d);
        return (d == 0) ? rcv0 : rcv1;
    endfunction
    function automatic logic [7:0] rdata_of(input int d);
        return (d == 0) ? rdata0 : rdata1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input int d, input logic r, input logic [7:0] a, input logic [7:0] w,
                           input logic [7:0] t, output int lat, output int bcyc, output int clow);
        int t0, b0, c0;
        @(posedge clk); #1;
        td0[d] = t; start[d] = 1'b1; rw[d] = r; addr[d] = a; wdata[d] = w;
        t0 = cyc; b0 = busy_cnt[d]; c0 = csn_cnt[d];
        @(posedge clk); #1;
        start[d] = 1'b0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done[d] === 1'b1) begin lat = cyc - t0; break; end
            @(posedge clk); #1;
        end
        @(negedge clk); #1;
        bcyc = busy_cnt[d] - b0;
        clow = csn_cnt[d] - c0;
    endtask

    typedef struct {
        int          d;
        logic        r;
        logic [7:0]  a, w, t;
        logic [23:0] frame;
        logic [7:0]  rdata;
        int          lat, bsy, csl;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int lat, bcyc, clow, t0, dc, nfr;
        for (int i = 0; i < 2; i++) begin addr[i] = '0; wdata[i] = '0; td0[i] = '0; end
        vecs[0] = '{0, 1'b0, 8'h0A, 8'h5A, 8'h00, 24'h400A5A, 8'h00, 209, 208, 200};
        vecs[1] = '{0, 1'b1, 8'h12, 8'h00, 8'hF0, 24'h411200, 8'hF0, 209, 208, 200};
        vecs[2] = '{0, 1'b1, 8'h34, 8'hEE, 8'hA5, 24'h413400, 8'hA5, 209, 208, 200};
        vecs[3] = '{0, 1'b0, 8'h56, 8'h3C, 8'h99, 24'h40563C, 8'hA5, 209, 208, 200};
        vecs[4] = '{1, 1'b1, 8'h07, 8'h00, 8'hC3, 24'h4B0700, 8'hC3, 157, 156, 150};
        vecs[5] = '{1, 1'b0, 8'h99, 8'h81, 8'h00, 24'h4A9981, 8'hC3, 157, 156, 150};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs0", {busy[0], done[0], sclk[0], csn[0], mosi[0], rdata0}, {4'b0001, 1'b0, 8'h00});
        chk("reset_outs1", {busy[1], done[1], sclk[1], csn[1], mosi[1], rdata1}, {4'b0001, 1'b0, 8'h00});
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("boot_flush_busy0", busy_cnt[0], 8);
        chk("boot_flush_busy1", busy_cnt[1], 6);
        chk("boot_flush_nodone", done_cnt[0] + done_cnt[1], 0);

        // Consecutive vectors start the cycle after the previous done.
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].d, vecs[i].r, vecs[i].a, vecs[i].w, vecs[i].t, lat, bcyc, clow);
            chk($sformatf("v%0d_done_latency", i), lat, vecs[i].lat);
            chk($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].bsy);
            chk($sformatf("v%0d_csn_low_cycles", i), clow, vecs[i].csl);
            chk($sformatf("v%0d_mosi_frame", i), frame_of(vecs[i].d), vecs[i].frame);
            chk($sformatf("v%0d_rdata", i), rdata_of(vecs[i].d), vecs[i].rdata);
            if (!vecs[i].r) chk($sformatf("v%0d_sink_rcv", i), rcv_of(vecs[i].d), vecs[i].w);
        end

        // Abort a read part way through the shift with reset.
        @(posedge clk); #1;
        td0[0] = 8'h77; start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'h20;
        dc = done_cnt[0]; nfr = nf0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (bc0 == 10) break;
            @(posedge clk); #1;
        end
        chk("abort_reached_bit10", bc0, 10);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle_outs", {busy[0], done[0], sclk[0], csn[0], mosi[0], rdata0}, {4'b0001, 1'b0, 8'h00});
        rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt[0] - dc, 0);
        chk("abort_no_frame", nf0 - nfr, 0);
        chk("abort_flush_over", busy[0], 0);
        run_txn(0, 1'b1, 8'h12, 8'h00, 8'h0F, lat, bcyc, clow);
        chk("after_abort_latency", lat, 209);
        chk("after_abort_frame", fr0, 24'h411200);
        chk("after_abort_rdata", rdata0, 8'h0F);

        // start pulsed at T0+50 while busy must be dropped.
        @(posedge clk); #1;
        start[0] = 1'b1; rw[0] = 1'b0; addr[0] = 8'h0A; wdata[0] = 8'h5A;
        t0 = cyc; dc = done_cnt[0]; nfr = nf0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (49) @(posedge clk);
        #1;
        start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 8'hFF;
        @(posedge clk); #1;
        start[0] = 1'b0;
        lat = -1;
        for (int i = 0; i < 2000; i++) begin
            if (done[0] === 1'b1) begin lat = cyc - t0; break; end
            @(posedge clk); #1;
        end
        chk("busy_start_latency", lat, 209);
        repeat (250) @(posedge clk);
        #1;
        chk("busy_start_one_done", done_cnt[0] - dc, 1);
        chk("busy_start_one_frame", nf0 - nfr, 1);
        chk("busy_start_frame", fr0, 24'h400A5A);
        chk("busy_start_rdata_kept", rdata0, 8'h0F);
        chk("busy_start_idle", busy[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
